fifo_stim_gen: RTL and testbench
================================

FIFO_STIM_GEN -- requirements
Module: fifo_stim_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of data_in, legal range 1..32.
REQ-002 SHALL have parameter NUM_TXN, default 10000: transactions per run, legal range >= 1.
REQ-003 SHALL have parameter RST_CYCLES, default 3: cycles dut_rst_n is held low at run start, legal range >= 1.
REQ-004 SHALL have parameters WR_ON_PCT (default 70), RD_ON_PCT (default 30) and DUT_RST_PCT (default 1): percent probabilities for random mode, each 0..100.
REQ-005 SHALL have parameter SEED, default 32'hACE1_2468: LFSR start value; a value of 0 SHALL be replaced by 32'h1.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all flops rising-edge); rst_n input 1 (asynchronous assert, active-low).
REQ-007 SHALL have start, input, 1 bit: pulse that begins a run.
REQ-008 SHALL have mode, input, 2 bits: 0 random, 1 write-burst, 2 read-burst, 3 alternate.
REQ-009 SHALL have dut_rst_n, output, 1 bit: reset driven to the FIFO under test.
REQ-010 SHALL have wr_en and rd_en, outputs, 1 bit each; data_in, output, DATA_WIDTH bits.
REQ-011 SHALL have sample, output, 1 bit: high when the driven values form a valid transaction for the scoreboard/coverage.
REQ-012 SHALL have busy and done, outputs, 1 bit each; txn_count, output, $clog2(NUM_TXN+1) bits.

Function
REQ-013 SHALL implement FSM states IDLE, RESET, RUN, DONE; all outputs SHALL be registered.
REQ-014 IDLE SHALL drive dut_rst_n=0, wr_en=rd_en=sample=0, busy=done=0; start=1 SHALL go to RESET.
REQ-015 On leaving IDLE or DONE, SHALL latch mode, clear txn_count to 0 and load LFSR with SEED.
REQ-016 RESET SHALL drive dut_rst_n=0 and busy=1 for exactly RST_CYCLES cycles, then go to RUN.
REQ-017 RUN SHALL emit one transaction per cycle, with sample=1, busy=1 and txn_count incremented by 1 in the same cycle.
REQ-018 RUN SHALL go to DONE in the cycle after txn_count reaches NUM_TXN.
REQ-019 LFSR SHALL be a 32-bit right-shift Galois type, mask 32'h8020_0003; it SHALL advance once per RUN cycle only.
REQ-020 In mode 0, wr_en SHALL equal (lfsr[6:0] < WR_ON_PCT*128/100), using integer division.
REQ-021 In mode 0, rd_en SHALL use lfsr[13:7] against RD_ON_PCT.
REQ-022 In mode 0, dut_rst_n SHALL be 0 when lfsr[20:14] < DUT_RST_PCT*128/100, and 1 otherwise.
REQ-023 In mode 1, outputs SHALL be wr_en=1, rd_en=0; in mode 2, wr_en=0, rd_en=1; in modes 1-3, dut_rst_n SHALL be 1.
REQ-024 In mode 3, wr_en SHALL be 1 on even transaction index (0-based) and rd_en SHALL be 1 on odd.
REQ-025 In all modes, data_in SHALL equal lfsr[DATA_WIDTH-1:0], taken from the value used for that transaction.
REQ-026 DONE SHALL drive dut_rst_n=1, wr_en=rd_en=sample=busy=0, done=1, and hold txn_count.
REQ-027 In DONE, start SHALL restart at RESET.
REQ-028 start SHALL be ignored in RESET and RUN; a mode change SHALL NOT take effect during a run.
REQ-029 Sequence SHALL be deterministic: the same SEED gives identical output streams on every run.

Reset
REQ-030 rst_n=0 SHALL, at any state including mid-RUN, immediately force IDLE outputs, txn_count=0 and LFSR=SEED.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-032 Case: rst_n=0 -> dut_rst_n=0, wr_en=rd_en=sample=busy=done=0, txn_count=0.
REQ-033 Case: NUM_TXN=8, mode=1, start pulse -> dut_rst_n low for 3 cycles; then 8 cycles of wr_en=1, rd_en=0, sample=1 with txn_count 1..8; then done=1 and busy=0.
REQ-034 Case: NUM_TXN=4, mode=3 -> wr_en 1,0,1,0 and rd_en 0,1,0,1; data_in matches the reference LFSR model from SEED.
REQ-035 Case: defaults, mode=0 -> over 10000 transactions, wr_en rate 0.70+-0.03, rd_en rate 0.30+-0.03, dut_rst_n low rate 0.01+-0.005; txn_count ends at 10000.
REQ-036 Case: rst_n pulsed at txn_count=5, then start -> outputs return to IDLE values immediately; the new run repeats the first-run data_in stream from SEED.
REQ-037 Case: start during RUN -> no effect on count or stream; start in DONE -> new RESET phase of 3 cycles and count restarts at 0.

Source files
------------

// File: rtl/fifo_stim_gen.sv
// Stimulus generator for a FIFO under test: reset phase, then NUM_TXN registered
// write/read/reset transactions driven from a Galois LFSR or a fixed pattern.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; FIFO held in reset, nothing driven
// S_RESET | FIFO held in reset for RST_CYCLES cycles, busy high
// S_RUN   | one transaction per cycle, sample high
// S_DONE  | run finished, done high, txn_count held; start restarts
module fifo_stim_gen #(
   parameter int          DATA_WIDTH  = 16,
   parameter int          NUM_TXN     = 10000,
   parameter int          RST_CYCLES  = 3,
   parameter int          WR_ON_PCT   = 70,
   parameter int          RD_ON_PCT   = 30,
   parameter int          DUT_RST_PCT = 1,
   parameter logic [31:0] SEED        = 32'hACE1_2468
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [1:0]                     mode,
   output logic                           dut_rst_n,
   output logic                           wr_en,
   output logic                           rd_en,
   output logic [DATA_WIDTH-1:0]          data_in,
   output logic                           sample,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(NUM_TXN+1)-1:0]   txn_count
);

   localparam int CNT_W = $clog2(NUM_TXN + 1);
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [31:0]      SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
   localparam logic [7:0]       WR_THR    = 8'(WR_ON_PCT * 128 / 100);
   localparam logic [7:0]       RD_THR    = 8'(RD_ON_PCT * 128 / 100);
   localparam logic [7:0]       RST_THR   = 8'(DUT_RST_PCT * 128 / 100);
   localparam logic [CNT_W-1:0] TXN_LAST  = CNT_W'(NUM_TXN);
   localparam logic [RC_W-1:0]  RC_INIT   = RC_W'(RST_CYCLES - 1);

   logic [1:0]      state;
   logic [1:0]      mode_q;
   logic [RC_W-1:0] rst_cnt;
   logic [31:0]     lfsr_q;
   logic [31:0]     lfsr_nxt;
   logic            launch;
   logic            emit;
   logic            txn_wr;
   logic            txn_rd;
   logic            txn_drn;

   always_comb begin
      lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
      launch   = start && ((state == S_IDLE) || (state == S_DONE));
      emit     = ((state == S_RESET) && (rst_cnt == '0)) ||
                 ((state == S_RUN) && (txn_count != TXN_LAST));
      txn_wr   = 1'b0;
      txn_rd   = 1'b0;
      txn_drn  = 1'b1;
      case (mode_q)
         2'd0: begin
            txn_wr  = {1'b0, lfsr_q[6:0]} < WR_THR;
            txn_rd  = {1'b0, lfsr_q[13:7]} < RD_THR;
            txn_drn = !({1'b0, lfsr_q[20:14]} < RST_THR);
         end
         2'd1: txn_wr = 1'b1;
         2'd2: txn_rd = 1'b1;
         default: begin
            // txn_count still holds the 0-based index of the transaction being emitted
            txn_wr = !txn_count[0];
            txn_rd = txn_count[0];
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mode_q    <= 2'd0;
         rst_cnt   <= '0;
         dut_rst_n <= 1'b0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         sample    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (launch) begin
         state     <= S_RESET;
         mode_q    <= mode;
         rst_cnt   <= RC_INIT;
         dut_rst_n <= 1'b0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         sample    <= 1'b0;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else if (emit) begin
         state     <= S_RUN;
         dut_rst_n <= txn_drn;
         wr_en     <= txn_wr;
         rd_en     <= txn_rd;
         sample    <= 1'b1;
         busy      <= 1'b1;
      end else if (state == S_RESET) begin
         rst_cnt   <= rst_cnt - RC_W'(1);
      end else if (state == S_RUN) begin
         state     <= S_DONE;
         dut_rst_n <= 1'b1;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         sample    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q    <= SEED_EFF;
         txn_count <= '0;
         data_in   <= '0;
      end else if (launch) begin
         lfsr_q    <= SEED_EFF;
         txn_count <= '0;
      end else if (emit) begin
         lfsr_q    <= lfsr_nxt;
         txn_count <= txn_count + CNT_W'(1);
         data_in   <= lfsr_q[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Directed bench for fifo_stim_gen: three instances (8, 4 and 10000 transactions)
// checked against a reference LFSR model through an expected-transaction queue.
module tb_fifo_stim_gen;

   localparam logic [31:0] SEED_REF = 32'hACE1_2468;
   localparam int          WR_THR_REF  = 70 * 128 / 100;
   localparam int          RD_THR_REF  = 30 * 128 / 100;
   localparam int          RST_THR_REF = 1 * 128 / 100;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic        drn;
      logic [15:0] data;
      logic [31:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_a [3];
   logic [1:0]  mode_a  [3];
   logic        drn_a   [3];
   logic        wr_a    [3];
   logic        rd_a    [3];
   logic        smp_a   [3];
   logic        busy_a  [3];
   logic        done_a  [3];
   logic [15:0] data_a  [3];
   logic [3:0]  cnt0;
   logic [2:0]  cnt1;
   logic [13:0] cnt2;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   wr_hits = 0;
   int   rd_hits = 0;
   int   drn_lows = 0;

   fifo_stim_gen #(.NUM_TXN(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_a[0]), .mode(mode_a[0]),
      .dut_rst_n(drn_a[0]), .wr_en(wr_a[0]), .rd_en(rd_a[0]), .data_in(data_a[0]),
      .sample(smp_a[0]), .busy(busy_a[0]), .done(done_a[0]), .txn_count(cnt0)
   );

   fifo_stim_gen #(.NUM_TXN(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a[1]), .mode(mode_a[1]),
      .dut_rst_n(drn_a[1]), .wr_en(wr_a[1]), .rd_en(rd_a[1]), .data_in(data_a[1]),
      .sample(smp_a[1]), .busy(busy_a[1]), .done(done_a[1]), .txn_count(cnt1)
   );

   fifo_stim_gen dut_l (
      .clk(clk), .rst_n(rst_n), .start(start_a[2]), .mode(mode_a[2]),
      .dut_rst_n(drn_a[2]), .wr_en(wr_a[2]), .rd_en(rd_a[2]), .data_in(data_a[2]),
      .sample(smp_a[2]), .busy(busy_a[2]), .done(done_a[2]), .txn_count(cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] cnt_of(input int k);
      case (k)
         0:       return 32'(cnt0);
         1:       return 32'(cnt1);
         default: return 32'(cnt2);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   // Reference model: expected stream for a run of n transactions in mode md.
   task automatic push_expected(input int n, input int md);
      logic [31:0] lf;
      exp_t        e;
      lf = SEED_REF;
      for (int i = 0; i < n; i++) begin
         e.data = lf[15:0];
         e.cnt  = 32'(i + 1);
         e.drn  = 1'b1;
         case (md)
            0: begin
               e.wr  = (int'(lf[6:0]) < WR_THR_REF);
               e.rd  = (int'(lf[13:7]) < RD_THR_REF);
               e.drn = !(int'(lf[20:14]) < RST_THR_REF);
            end
            1: begin e.wr = 1'b1; e.rd = 1'b0; end
            2: begin e.wr = 1'b0; e.rd = 1'b1; end
            default: begin e.wr = (i % 2 == 0); e.rd = (i % 2 == 1); end
         endcase
         q.push_back(e);
         lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
      end
   endtask

   task automatic check_idle(input int k, input string where);
      chk($sformatf("%s_drn%0d", where, k),   32'(drn_a[k]),  32'd0);
      chk($sformatf("%s_wr%0d", where, k),    32'(wr_a[k]),   32'd0);
      chk($sformatf("%s_rd%0d", where, k),    32'(rd_a[k]),   32'd0);
      chk($sformatf("%s_smp%0d", where, k),   32'(smp_a[k]),  32'd0);
      chk($sformatf("%s_busy%0d", where, k),  32'(busy_a[k]), 32'd0);
      chk($sformatf("%s_done%0d", where, k),  32'(done_a[k]), 32'd0);
      chk($sformatf("%s_cnt%0d", where, k),   cnt_of(k),      32'd0);
   endtask

   // Pulse start, push expectations, then check the reset phase cycle by cycle.
   task automatic start_run(input int k, input int md, input int n);
      mode_a[k] = 2'(md);
      q.delete();
      push_expected(n, md);
      @(negedge clk) start_a[k] = 1'b1;
      @(negedge clk) start_a[k] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rstph_drn%0d_c%0d", k, c),  32'(drn_a[k]),  32'd0);
         chk($sformatf("rstph_busy%0d_c%0d", k, c), 32'(busy_a[k]), 32'd1);
         chk($sformatf("rstph_smp%0d_c%0d", k, c),  32'(smp_a[k]),  32'd0);
         chk($sformatf("rstph_cnt%0d_c%0d", k, c),  cnt_of(k),      32'd0);
         @(negedge clk);
      end
   endtask

   // Pop and compare one transaction per cycle; optional start/mode poke and abort.
   task automatic run_check(input int k, input int n, input int poke_at, input int abort_at);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("sample%0d_t%0d", k, i), 32'(smp_a[k]), 32'd1);
         e = q.pop_front();
         chk($sformatf("wr%0d_t%0d", k, i),   32'(wr_a[k]),   32'(e.wr));
         chk($sformatf("rd%0d_t%0d", k, i),   32'(rd_a[k]),   32'(e.rd));
         chk($sformatf("drn%0d_t%0d", k, i),  32'(drn_a[k]),  32'(e.drn));
         chk($sformatf("data%0d_t%0d", k, i), 32'(data_a[k]), 32'(e.data));
         chk($sformatf("cnt%0d_t%0d", k, i),  cnt_of(k),      e.cnt);
         if (k == 2) begin
            wr_hits  += int'(wr_a[k]);
            rd_hits  += int'(rd_a[k]);
            drn_lows += int'(!drn_a[k]);
         end
         if (i + 1 == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_idle(k, "abort");
            q.delete();
            @(negedge clk) rst_n = 1'b1;
            return;
         end
         if (i + 1 == poke_at) begin
            start_a[k] = 1'b1;
            mode_a[k]  = ~mode_a[k];
         end else begin
            start_a[k] = 1'b0;
         end
         @(negedge clk);
      end
      start_a[k] = 1'b0;
   endtask

   task automatic check_done(input int k, input int n);
      chk($sformatf("done%0d", k),      32'(done_a[k]), 32'd1);
      chk($sformatf("done_busy%0d", k), 32'(busy_a[k]), 32'd0);
      chk($sformatf("done_smp%0d", k),  32'(smp_a[k]),  32'd0);
      chk($sformatf("done_drn%0d", k),  32'(drn_a[k]),  32'd1);
      chk($sformatf("done_cnt%0d", k),  cnt_of(k),      32'(n));
      @(negedge clk);
      chk($sformatf("hold_done%0d", k), 32'(done_a[k]), 32'd1);
      chk($sformatf("hold_cnt%0d", k),  cnt_of(k),      32'(n));
   endtask

   initial begin
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_a[k] = 1'b0;
         mode_a[k]  = 2'd0;
      end
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) check_idle(k, "por");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle(0, "idle_wait");

      // Write burst with a start pulse and mode change injected mid-run.
      start_run(0, 1, 8);
      run_check(0, 8, 3, 0);
      check_done(0, 8);

      // Restart from DONE in read-burst mode, abort with rst_n at count 5.
      start_run(0, 2, 8);
      run_check(0, 8, 0, 5);
      repeat (3) @(negedge clk);
      check_idle(0, "post_abort");

      // Fresh run must replay the stream from SEED.
      start_run(0, 2, 8);
      run_check(0, 8, 0, 0);
      check_done(0, 8);

      // Alternate mode, four transactions.
      start_run(1, 3, 4);
      run_check(1, 4, 0, 0);
      check_done(1, 4);

      // Random mode, full default run.
      start_run(2, 0, 10000);
      run_check(2, 10000, 0, 0);
      check_done(2, 10000);
      chk("wr_rate_0.67_0.73",   32'(wr_hits >= 6700 && wr_hits <= 7300), 32'd1);
      chk("rd_rate_0.27_0.33",   32'(rd_hits >= 2700 && rd_hits <= 3300), 32'd1);
      chk("drn_low_0.005_0.015", 32'(drn_lows >= 50 && drn_lows <= 150),  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
